// File: rtl/ddr_io_slice.sv
// Bit-sliced DDR I/O cell: DDR output register, DDR input capture, tristate pad, forwarded clock.
// Define DDR_IN_RETIME_EN to add a posedge retime stage that aligns {q1,q0} to one clock cycle.
module ddr_io_slice #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_0,
    input  logic             rst_n,
    input  logic             oe,
    input  logic             ce,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    inout  wire  [WIDTH-1:0] pad,
    output logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic             ck_o,
    output logic             ck_n_o
);

    logic [WIDTH-1:0] r_r0;
    logic [WIDTH-1:0] r_r1;
    logic [WIDTH-1:0] r_a0;
    logic [WIDTH-1:0] r_a1;
    logic             r_ck_p;
    logic             r_ck_n;
    logic             r_ckb_p;
    logic             r_ckb_n;
    logic [WIDTH-1:0] w_pad_out;

    // Rising-edge half of the output and clock-forward registers.
    always_ff @(posedge clk_0 or negedge rst_n) begin
        if (!rst_n) begin
            r_r0    <= '0;
            r_ck_p  <= 1'b0;
            r_ckb_p <= 1'b0;
        end else begin
            if (ce) begin
                r_r0 <= d0;
            end
            r_ck_p  <= 1'b1;
            r_ckb_p <= 1'b0;
        end
    end

    always_ff @(negedge clk_0 or negedge rst_n) begin
        if (!rst_n) begin
            r_r1    <= '0;
            r_ck_n  <= 1'b0;
            r_ckb_n <= 1'b0;
        end else begin
            if (ce) begin
                r_r1 <= d1;
            end
            r_ck_n  <= 1'b0;
            r_ckb_n <= 1'b1;
        end
    end

    assign w_pad_out = clk_0 ? r_r0 : r_r1;
    assign pad       = oe ? w_pad_out : {WIDTH{1'bz}};
    assign pad_i     = pad;

    // Clock outputs share the data mux structure so pad delays match.
    assign ck_o   = clk_0 ? r_ck_p : r_ck_n;
    assign ck_n_o = clk_0 ? r_ckb_p : r_ckb_n;

    always_ff @(posedge clk_0 or negedge rst_n) begin
        if (!rst_n) begin
            r_a0 <= '0;
        end else begin
            r_a0 <= pad;
        end
    end

    always_ff @(negedge clk_0 or negedge rst_n) begin
        if (!rst_n) begin
            r_a1 <= '0;
        end else begin
            r_a1 <= pad;
        end
    end

`ifdef DDR_IN_RETIME_EN
    logic [WIDTH-1:0] r_q0;
    logic [WIDTH-1:0] r_q1;

    always_ff @(posedge clk_0 or negedge rst_n) begin
        if (!rst_n) begin
            r_q0 <= '0;
            r_q1 <= '0;
        end else begin
            r_q0 <= r_a0;
            r_q1 <= r_a1;
        end
    end

    assign q0 = r_q0;
    assign q1 = r_q1;
`else
    assign q0 = r_a0;
    assign q1 = r_a1;
`endif

endmodule

// File: tb/tb_ddr_io_slice.sv
// Self-checking bench for ddr_io_slice: scoreboard queue of expected pad/capture values.
// Timing of q0/q1 checks follows DDR_IN_RETIME_EN when it is defined for the build.
module tb_ddr_io_slice;

    localparam int unsigned WIDTH = 16;

    logic             clk_0;
    logic             rst_n;
    logic             oe;
    logic             ce;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    wire  [WIDTH-1:0] pad;
    logic [WIDTH-1:0] pad_i;
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;
    logic             ck_o;
    logic             ck_n_o;

    logic             r_drv_en;
    logic [WIDTH-1:0] r_drv_val;

    int unsigned      n_vec;
    int unsigned      n_err;

    logic [WIDTH-1:0] exp_pad[$];
    logic [WIDTH-1:0] exp_q0[$];
    logic [WIDTH-1:0] exp_q1[$];

    assign pad = r_drv_en ? r_drv_val : {WIDTH{1'bz}};

    ddr_io_slice #(
        .WIDTH (WIDTH)
    ) u_dut (
        .clk_0  (clk_0),
        .rst_n  (rst_n),
        .oe     (oe),
        .ce     (ce),
        .d0     (d0),
        .d1     (d1),
        .pad    (pad),
        .pad_i  (pad_i),
        .q0     (q0),
        .q1     (q1),
        .ck_o   (ck_o),
        .ck_n_o (ck_n_o)
    );

    initial clk_0 = 1'b0;
    always #5 clk_0 = ~clk_0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic to_high();
        @(posedge clk_0);
        #2;
    endtask

    task automatic to_low();
        @(negedge clk_0);
        #2;
    endtask

    task automatic check_pad_pop(input string tag);
        logic [WIDTH-1:0] e;
        if (exp_pad.size() == 0) begin
            check_eq({tag, "_underflow"}, 32'd1, 32'd0);
        end else begin
            e = exp_pad.pop_front();
            check_eq(tag, {16'd0, pad_i}, {16'd0, e});
        end
    endtask

    task automatic check_q_pop(input bit which, input string tag);
        logic [WIDTH-1:0] e;
        if ((which ? exp_q1.size() : exp_q0.size()) == 0) begin
            check_eq({tag, "_underflow"}, 32'd1, 32'd0);
        end else if (which) begin
            e = exp_q1.pop_front();
            check_eq(tag, {16'd0, q1}, {16'd0, e});
        end else begin
            e = exp_q0.pop_front();
            check_eq(tag, {16'd0, q0}, {16'd0, e});
        end
    endtask

    initial begin
        logic [WIDTH-1:0] x0;
        logic [WIDTH-1:0] x1;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        oe        = 1'b1;
        ce        = 1'b0;
        d0        = '0;
        d1        = '0;
        r_drv_en  = 1'b0;
        r_drv_val = '0;

        // Reset state, both clock phases.
        #2;
        check_eq("rst_pad_low", {16'd0, pad}, 32'd0);
        check_eq("rst_q0", {16'd0, q0}, 32'd0);
        check_eq("rst_q1", {16'd0, q1}, 32'd0);
        check_eq("rst_ck_low", {30'd0, ck_o, ck_n_o}, 32'd0);
        #5;
        check_eq("rst_pad_high", {16'd0, pad_i}, 32'd0);
        check_eq("rst_ck_high", {30'd0, ck_o, ck_n_o}, 32'd0);
        oe        = 1'b0;
        r_drv_en  = 1'b1;
        r_drv_val = 16'h0F0F;
        #1;
        check_eq("rst_hiz_readback", {16'd0, pad_i}, 32'h0F0F);
        r_drv_en = 1'b0;

        // Release reset in the low phase; clocks forward from the next edge.
        to_low();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            to_high();
            check_eq("ckfwd_high", {30'd0, ck_o, ck_n_o}, 32'b10);
            to_low();
            check_eq("ckfwd_low", {30'd0, ck_o, ck_n_o}, 32'b01);
        end

        // DDR write with a fixed pattern, then random patterns.
        oe = 1'b1;
        ce = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x0 = (i == 0) ? 16'hA5A5 : WIDTH'($urandom);
            x1 = (i == 0) ? 16'h5A5A : WIDTH'($urandom);
            d0 = x0;
            d1 = x1;
            exp_pad.push_back(x0);
            exp_pad.push_back(x1);
            to_high();
            check_pad_pop("wr_high");
            if (i == 0) check_eq("wr_pad_net", {16'd0, pad}, 32'hA5A5);
            to_low();
            check_pad_pop("wr_low");
        end

        // ce hold: registers keep 0x1234/0x4321 while inputs change.
        d0 = 16'h1234;
        d1 = 16'h4321;
        to_high();
        to_low();
        ce = 1'b0;
        d0 = 16'hFFFF;
        d1 = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            exp_pad.push_back(16'h1234);
            exp_pad.push_back(16'h4321);
            to_high();
            check_pad_pop("hold_high");
            to_low();
            check_pad_pop("hold_low");
        end

        // Turnaround mid-burst: pad released, read-back follows external driver.
        ce = 1'b1;
        d0 = 16'h7777;
        d1 = 16'h8888;
        to_high();
        to_low();
        to_high();
        check_eq("ta_driven", {16'd0, pad_i}, 32'h7777);
        oe        = 1'b0;
        r_drv_en  = 1'b1;
        r_drv_val = 16'h3C3C;
        #1;
        check_eq("ta_released", {16'd0, pad_i}, 32'h3C3C);

        // DDR read: BEEF before posedge k, CAFE before the following negedge.
        to_low();
        for (int i = 0; i < 5; i++) begin
            x0 = (i == 0) ? 16'hBEEF : WIDTH'($urandom);
            x1 = (i == 0) ? 16'hCAFE : WIDTH'($urandom);
            r_drv_val = x0;
            exp_q0.push_back(x0);
            exp_q1.push_back(x1);
            to_high();
`ifdef DDR_IN_RETIME_EN
            if (i > 0) begin
                check_q_pop(1'b0, "rd_q0");
                check_q_pop(1'b1, "rd_q1");
            end
`else
            check_q_pop(1'b0, "rd_q0");
`endif
            r_drv_val = x1;
            #1;
            check_eq("rd_pad_i", {16'd0, pad_i}, {16'd0, x1});
            to_low();
`ifndef DDR_IN_RETIME_EN
            check_q_pop(1'b1, "rd_q1");
`endif
        end
`ifdef DDR_IN_RETIME_EN
        to_high();
        check_q_pop(1'b0, "rd_q0_last");
        check_q_pop(1'b1, "rd_q1_last");
`endif

        // Mid-run reset clears everything asynchronously.
        r_drv_en = 1'b0;
        oe       = 1'b1;
        d0       = 16'h9999;
        d1       = 16'h6666;
        to_high();
        to_low();
        to_high();
        check_eq("pre_rst_pad", {16'd0, pad_i}, 32'h9999);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_pad", {16'd0, pad_i}, 32'd0);
        check_eq("midrst_ck", {30'd0, ck_o, ck_n_o}, 32'd0);
        check_eq("midrst_q0", {16'd0, q0}, 32'd0);
        check_eq("midrst_q1", {16'd0, q1}, 32'd0);
        to_low();
        check_eq("midrst_pad_low", {16'd0, pad_i}, 32'd0);
        check_eq("midrst_ck_low", {30'd0, ck_o, ck_n_o}, 32'd0);

        check_eq("sb_empty", exp_pad.size() + exp_q0.size() + exp_q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ddr_io_slice.md
Name: ddr_io_slice

Overview:
- Bit-sliced DDR I/O cell for the memory-controller PHY; sits between controller datapath and external DDR SDRAM pins (DQ/DM/DQS).
- Combines three functions per bit: a DDR output register, a DDR input capture register, and a bidirectional tristate pad buffer.
- Also produces a forwarded differential clock with the same register-to-pad delay as the data.

Parameters:
- WIDTH, 16, number of bidirectional pad bits in the slice.

Ports:
- clk_0  input  1  single system clock; rising and falling edges both used.
- rst_n  input  1  asynchronous active-low reset.
- oe  input  1  pad output enable; 1 = drive pad, 0 = high-Z.
- ce  input  1  output-register clock enable.
- d0  input  WIDTH  data launched on the rising edge (high phase).
- d1  input  WIDTH  data launched on the falling edge (low phase).
- pad  inout  WIDTH  external bidirectional pins.
- pad_i  output  WIDTH  unregistered pad read-back, valid while driving and while high-Z.
- q0  output  WIDTH  pad data captured at the rising edge.
- q1  output  WIDTH  pad data captured at the following falling edge.
- ck_o  output  1  forwarded clock.
- ck_n_o  output  1  forwarded complement clock.

Behaviour:
- Output register r0: loads d0 at posedge clk_0 when ce=1.
- Output register r1: loads d1 at negedge clk_0 when ce=1.
- Both registers hold their value when ce=0.
- Output mux: pad_out = clk_0 ? r0 : r1.
  - A value presented on d0 before posedge k drives the pad for the high phase after posedge k.
  - A value on d1 before the next negedge drives the low phase.
- Tristate: pad = oe ? pad_out : all-Z. oe is combinational, with no registering.
- Read-back: pad_i = pad at all times.
- Input capture:
  - a0 samples pad at posedge.
  - a1 samples pad at negedge.
  - No enable on the capture path.
- Retime stage (see Optional Feature): at posedge k+1, q0 <= a0 from posedge k and q1 <= a1 from the negedge between k and k+1.
  - {q1,q0} always form one coherent clock-cycle pair, updated on rising edges only.
- Forwarded clock:
  - ck_o uses the same DDR output structure with d0=1, d1=0, ce forced 1.
  - ck_n_o uses d0=0, d1=1.
  - ck_n_o is always the complement of ck_o once out of reset.
- Reset (asynchronous, rst_n=0):
  - r0, r1, a0, a1, q0, q1 all clear to 0.
  - ck registers clear so that ck_o=0 and ck_n_o=0 during reset.
  - Pad drives 0 if oe=1, else Z.
- Reset release: the clock outputs resume toggling from the first edge after rst_n rises.
- Mid-operation reset clears in-flight data immediately, with no partial pairs emitted.
- Simultaneous oe change and data edge: the pad follows oe in the same delta, with no extra cycle.

Optional Feature:
- Macro: DDR_IN_RETIME_EN.
- Defined: the retime stage is present; q0/q1 have one-cycle latency and update only at posedge.
- Undefined: q0 = a0 and q1 = a1 directly.
  - q0 changes at posedge; q1 changes at negedge.
  - Latency is zero, but the pair is not edge-aligned.

Test Plan:
- Reset: rst_n=0 with oe=1 -> pad=0x0000, q0=q1=0, ck_o=ck_n_o=0; with oe=0 -> pad all Z.
- DDR write: oe=1, ce=1, d0=0xA5A5 and d1=0x5A5A held -> pad=0xA5A5 during the high phase and 0x5A5A during the low phase; pad_i matches.
- ce hold: load d0=0x1234, d1=0x4321; set ce=0 and change d0/d1 to 0xFFFF -> pad keeps alternating 0x1234/0x4321.
- DDR read: oe=0; bench drives pad 0xBEEF before posedge k and 0xCAFE before the following negedge -> after posedge k+1, q0=0xBEEF and q1=0xCAFE (with DDR_IN_RETIME_EN); without the macro, q0=0xBEEF at posedge k and q1=0xCAFE at the negedge.
- Turnaround: oe toggled 1->0 mid-burst -> pad goes Z immediately and pad_i follows the external driver.
- Clock forward: after reset release -> ck_o equals clk_0 and ck_n_o equals ~clk_0 every cycle; assert rst_n=0 mid-run -> both outputs drop to 0 asynchronously.
